// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    localparam int DEFAULT_HOLD_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        HOLD,
        CHECK,
        FINISH
    } state_t;

endpackage

// File: rtl/prog_loader_hold_timer.sv
// Counts the cycles an address/data pair is held for the RAM write.
// expire pulses in the last held cycle.
module hold_timer
    import prog_loader_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'd0;
        end else if (count) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = count && (cnt == 8'(HOLD_CYCLES - 1));

endmodule

// File: rtl/prog_loader.sv
// Byte-serial program loader: writes DEPTH host bytes into CPU RAM.
// Optional trailing checksum byte is enabled by macro PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int DEPTH       = 16
) (
    input  logic       fastClk,
    input  logic       rst,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       prog_mode,
    output logic [3:0] prog_addr,
    output logic [7:0] prog_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    state_t state, next_state;
    logic   launch;
    logic   accept;
    logic   advance;
    logic   hold_expire;

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk    (fastClk),
        .rst    (rst),
        .load   (accept),
        .count  (state == HOLD),
        .expire (hold_expire)
    );

    always_ff @(posedge fastClk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       sum_check;
`endif

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        prog_mode  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        launch     = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_check  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    next_state = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                byte_ready = 1'b1;
                prog_mode  = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    accept     = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                prog_mode = 1'b1;
                busy      = 1'b1;
                if (hold_expire) begin
                    if (prog_addr == LAST_ADDR) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        next_state = CHECK;
`else
                        next_state = FINISH;
`endif
                    end else begin
                        advance    = 1'b1;
                        next_state = WAIT_BYTE;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                prog_mode  = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    sum_check  = 1'b1;
                    next_state = FINISH;
                end
            end
`endif
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address/data registers keep their last values after FINISH.
    always_ff @(posedge fastClk) begin
        if (rst) begin
            prog_addr <= 4'd0;
            prog_data <= 8'd0;
        end else begin
            if (launch) begin
                prog_addr <= 4'd0;
            end else if (advance) begin
                prog_addr <= prog_addr + 4'd1;
            end
            if (accept) begin
                prog_data <= byte_data;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge fastClk) begin
        if (rst) begin
            csum <= 8'd0;
            err  <= 1'b0;
        end else if (launch) begin
            csum <= 8'd0;
            err  <= 1'b0;
        end else begin
            if (accept) begin
                csum <= csum + byte_data;
            end
            if (sum_check && (byte_data != csum)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: default instance plus a HOLD_CYCLES=1 instance.
module tb_prog_loader;

    localparam int HC    = 4;
    localparam int DEPTH = 16;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int EXP_LEN = DEPTH * (HC + 1) + 2;
`else
    localparam int EXP_LEN = DEPTH * (HC + 1) + 1;
`endif

    logic       clk;
    logic       rst;
    logic       start, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, prog_mode, busy, done, err;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;

    logic       f_start, f_valid;
    logic [7:0] f_data;
    logic       f_ready, f_mode, f_busy, f_done, f_err;
    logic [3:0] f_addr;
    logic [7:0] f_pdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;

    logic [11:0] expq[$];
    logic [11:0] cur;
    int          mon_cnt  = 0;
    bit          mon_exit = 0;

    prog_loader u_dut (
        .fastClk    (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .prog_mode  (prog_mode),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    prog_loader #(.HOLD_CYCLES(1), .DEPTH(DEPTH)) u_fast (
        .fastClk    (clk),
        .rst        (rst),
        .start      (f_start),
        .byte_valid (f_valid),
        .byte_data  (f_data),
        .byte_ready (f_ready),
        .prog_mode  (f_mode),
        .prog_addr  (f_addr),
        .prog_data  (f_pdata),
        .busy       (f_busy),
        .done       (f_done),
        .err        (f_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pops one expected pair per program-byte handshake and checks the hold window.
    always @(negedge clk) begin
        logic [3:0] na;
        if (rst) begin
            mon_cnt  = 0;
            mon_exit = 0;
            expq.delete();
        end else begin
            if (done) done_cnt++;
            if (mon_cnt > 0) begin
                chk("hold_addr", 32'(prog_addr), 32'(cur[11:8]));
                chk("hold_data", 32'(prog_data), 32'(cur[7:0]));
                chk("hold_ready", 32'(byte_ready), 32'd0);
                mon_cnt--;
                if (mon_cnt == 0) mon_exit = 1;
            end else begin
                if (mon_exit) begin
                    mon_exit = 0;
                    na = (cur[11:8] == 4'd15) ? 4'd15 : cur[11:8] + 4'd1;
                    chk("hold_exit", 32'(byte_ready | done), 32'd1);
                    chk("next_addr", 32'(prog_addr), 32'(na));
                end
                if (byte_valid && byte_ready && expq.size() > 0) begin
                    cur = expq.pop_front();
                    mon_cnt = HC;
                end
            end
        end
    end

    task automatic wait_hs();
        int n = 0;
        bit ok;
        forever begin
            @(negedge clk);
            ok = byte_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 300) begin
                chk("hs_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic send_byte(input logic [3:0] a, input logic [7:0] d, input int stall,
                             input logic [7:0] prev);
        int n = 0;
        if (stall > 0) begin
            byte_valid = 1'b0;
            @(negedge clk);
            while (!byte_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            repeat (stall) begin
                chk("stall_ready", 32'(byte_ready), 32'd1);
                chk("stall_addr", 32'(prog_addr), 32'(a));
                chk("stall_data", 32'(prog_data), 32'(prev));
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        expq.push_back({a, d});
        byte_valid = 1'b1;
        byte_data  = d;
        wait_hs();
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] base, input logic [7:0] step);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < DEPTH; i++) s = s + 8'(base + step * 8'(i));
        return s;
    endfunction

    task automatic run_load(input logic [7:0] base, input logic [7:0] step, input int stall_idx,
                            input int start_idx, input logic [7:0] csum_byte,
                            input logic exp_err, input int exp_len);
        int t0;
        int n = 0;
        logic [7:0] d;
        logic [7:0] last = 8'd0;
        t0 = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_mode", 32'(prog_mode), 32'd1);
        chk("start_addr", 32'(prog_addr), 32'd0);
        chk("start_err", 32'(err), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(base + step * 8'(i));
            send_byte(4'(i), d, (i == stall_idx) ? 20 : 0, last);
            last = d;
            if (i == start_idx) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("ignored_start_busy", 32'(busy), 32'd1);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        byte_valid = 1'b1;
        byte_data  = csum_byte;
        wait_hs();
`else
        if (csum_byte != csum_of(base, step)) chk("csum_arg", 32'(csum_byte), 32'(csum_of(base, step)));
`endif
        byte_valid = 1'b0;
        @(negedge clk);
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        if (exp_len > 0) chk("session_len", 32'(cyc - t0), 32'(exp_len));
        chk("done_mode", 32'(prog_mode), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_addr", 32'(prog_addr), 32'd15);
        chk("done_data", 32'(prog_data), 32'(last));
        chk("done_err", 32'(err), 32'(exp_err));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("err_sticky", 32'(err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dc;
        int n;
        int hs_cyc;
        int prev_hs;
        bit ok;
        rst = 1'b1;
        start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
        f_start = 1'b0; f_valid = 1'b0; f_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_mode", 32'(prog_mode), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(prog_addr), 32'd0);
        chk("rst_data", 32'(prog_data), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full back-to-back load with latency check.
        run_load(8'h10, 8'd1, -1, -1, csum_of(8'h10, 8'd1), 1'b0, EXP_LEN);
        // Stall before byte 3 and an ignored start at address 7.
        run_load(8'h40, 8'd3, 3, 7, csum_of(8'h40, 8'd3), 1'b0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        run_load(8'h01, 8'd0, -1, -1, 8'h10, 1'b0, 0);
        run_load(8'h01, 8'd0, -1, -1, 8'h11, 1'b1, 0);
        run_load(8'h20, 8'd1, -1, -1, csum_of(8'h20, 8'd1), 1'b0, 0);
`endif

        // Reset in the middle of the hold window of address 5.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(4'(i), 8'(8'h60 + i), 0, 8'h00);
        @(posedge clk);
        #1;
        chk("pre_rst_addr", 32'(prog_addr), 32'd5);
        byte_valid = 1'b0;
        dc = done_cnt;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(byte_ready), 32'd0);
        chk("abort_mode", 32'(prog_mode), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_addr", 32'(prog_addr), 32'd0);
        chk("abort_data", 32'(prog_data), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'(dc));
        @(posedge clk);
        #1;

        // HOLD_CYCLES=1 instance: a new address every 2 cycles.
        f_start = 1'b1;
        @(posedge clk);
        #1;
        f_start = 1'b0;
        prev_hs = -1;
        for (int i = 0; i < DEPTH; i++) begin
            f_valid = 1'b1;
            f_data  = 8'(8'hA0 + i);
            n = 0;
            forever begin
                @(negedge clk);
                ok = f_ready;
                @(posedge clk);
                #1;
                if (ok || n > 50) break;
                n++;
            end
            hs_cyc = cyc;
            @(negedge clk);
            chk("fast_addr", 32'(f_addr), 32'(i));
            chk("fast_data", 32'(f_pdata), 32'(8'hA0 + i));
            if (prev_hs >= 0) chk("fast_gap", 32'(hs_cyc - prev_hs), 32'd2);
            prev_hs = hs_cyc;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        f_data = csum_of(8'hA0, 8'd1);
        @(posedge clk);
        #1;
`endif
        f_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!f_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fast_done", 32'(f_done), 32'd1);
        chk("fast_last_addr", 32'(f_addr), 32'd15);
        chk("fast_last_data", 32'(f_pdata), 32'hAF);
        chk("fast_err", 32'(f_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
